// File: rtl/menu_nav_fsm.sv
// Menu selection navigator fed by the PS/2 byte stream.
// Handles direct-jump keys, up/down wrap and an ENTER/BACK lock handshake.
module menu_nav_fsm #(
    parameter int unsigned NUM_ITEMS  = 4,
    parameter int unsigned SEL_W      = 3,
    parameter logic [7:0]  UP_CODE    = 8'h75,
    parameter logic [7:0]  DOWN_CODE  = 8'h72,
    parameter logic [7:0]  ENTER_CODE = 8'h5A,
    parameter logic [7:0]  BACK_CODE  = 8'h76
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   ps2_key_pressed,
    input  logic [7:0]             ps2_key_data,
    input  logic [8*NUM_ITEMS-1:0] key_table,
    output logic [SEL_W-1:0]       menu_sel,
    output logic                   locked,
    output logic                   confirm_pulse,
    output logic                   back_pulse
);

    typedef enum logic {
        BROWSE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] BRK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE = 8'hE0;

    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_ITEMS - 1);
    localparam logic [SEL_W-1:0] ZERO = '0;
    localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

    state_t           state;
    logic             brk_flag;
    logic             ext_flag;
    logic             tbl_hit;
    logic [SEL_W-1:0] tbl_idx;
    logic [SEL_W-1:0] sel_up;
    logic [SEL_W-1:0] sel_dn;

    // Scan from the top so the lowest matching index is the one kept.
    always_comb begin
        tbl_hit = 1'b0;
        tbl_idx = ZERO;
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (key_table[8*i +: 8] == ps2_key_data) begin
                tbl_hit = 1'b1;
                tbl_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sel_up = (menu_sel == ZERO) ? LAST : menu_sel - ONE;
        sel_dn = (menu_sel == LAST) ? ZERO : menu_sel + ONE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= BROWSE;
            menu_sel      <= ZERO;
            locked        <= 1'b0;
            confirm_pulse <= 1'b0;
            back_pulse    <= 1'b0;
            brk_flag      <= 1'b0;
            ext_flag      <= 1'b0;
        end else begin
            confirm_pulse <= 1'b0;
            back_pulse    <= 1'b0;
            if (ps2_key_pressed) begin
                if (ps2_key_data == BRK_CODE) begin
                    brk_flag <= 1'b1;
                    // An E0 F0 release keeps the extended marker until the release byte.
                    ext_flag <= ext_flag;
                end else if (ps2_key_data == EXT_CODE) begin
                    ext_flag <= 1'b1;
                end else if (brk_flag) begin
                    brk_flag <= 1'b0;
                    ext_flag <= 1'b0;
                end else begin
                    ext_flag <= 1'b0;
                    if (enable) begin
                        unique case (state)
                            BROWSE: begin
                                if (ps2_key_data == BACK_CODE) begin
                                    state <= BROWSE;
                                end else if (ps2_key_data == ENTER_CODE) begin
                                    state         <= LOCKED;
                                    locked        <= 1'b1;
                                    confirm_pulse <= 1'b1;
                                end else if (ps2_key_data == UP_CODE) begin
                                    menu_sel <= sel_up;
                                end else if (ps2_key_data == DOWN_CODE) begin
                                    menu_sel <= sel_dn;
                                end else if (tbl_hit) begin
                                    menu_sel <= tbl_idx;
                                end
                            end
                            LOCKED: begin
                                if (ps2_key_data == BACK_CODE) begin
                                    state      <= BROWSE;
                                    locked     <= 1'b0;
                                    back_pulse <= 1'b1;
                                end
                            end
                            default: state <= BROWSE;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: doc/menu_nav_fsm.md
Name: menu_nav_fsm

Overview:
Registered, parametrised menu navigator driven by the PS/2 byte stream. It holds the current selection among NUM_ITEMS entries and supports:
- direct-jump keys, one per item, supplied as a flattened table;
- up/down stepping with wrap-around;
- an ENTER/BACK lock-confirm handshake.

It filters PS/2 break (F0) and extended (E0) prefixes so that key releases never act. It sits between the PS/2 receiver and the game/menu screen logic.

Parameters:
NUM_ITEMS, 4, number of menu entries (2..8)
SEL_W, 3, width of selection index; must satisfy 2^SEL_W >= NUM_ITEMS
UP_CODE, 8'h75, scan code for step up (accepted with or without E0 prefix)
DOWN_CODE, 8'h72, scan code for step down (accepted with or without E0 prefix)
ENTER_CODE, 8'h5A, scan code for confirm
BACK_CODE, 8'h76, scan code for unlock/back

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  when 0, no navigation actions; prefix tracking continues
ps2_key_pressed  input  1  one-cycle strobe: ps2_key_data valid this cycle
ps2_key_data  input  8  received PS/2 byte
key_table  input  8*NUM_ITEMS  direct-jump codes; item i uses bits [8i+7:8i]
menu_sel  output  SEL_W  current selection index, registered
locked  output  1  1 while a selection is confirmed
confirm_pulse  output  1  one-cycle pulse on ENTER accepted
back_pulse  output  1  one-cycle pulse on BACK accepted

Behaviour:
- Reset (synchronous, priority over everything):
  - menu_sel=0, locked=0, confirm_pulse=0, back_pulse=0;
  - brk_flag=0, ext_flag=0;
  - state=BROWSE.
  - Reset mid-prefix discards the pending prefix.
- Bytes are consumed only on cycles with ps2_key_pressed=1. All other cycles hold state, and both pulses return to 0.
- Prefix filter, evaluated every strobe regardless of enable:
  - data==F0: brk_flag<=1, no action.
  - data==E0: ext_flag<=1, no action.
  - Any other byte with brk_flag=1: byte consumed as a release; clear brk_flag and ext_flag; no action.
  - Any other byte with brk_flag=0: this is a "make byte"; clear ext_flag after use.
  - F0 following E0 keeps ext_flag set until the release byte is consumed.
- A make byte acts only if enable=1. Evaluation order (first match wins):
  - In BROWSE:
    1. BACK_CODE: no action.
    2. ENTER_CODE: locked<=1, confirm_pulse<=1, state<=LOCKED.
    3. UP_CODE: menu_sel<=(menu_sel==0)?NUM_ITEMS-1:menu_sel-1.
    4. DOWN_CODE: menu_sel<=(menu_sel==NUM_ITEMS-1)?0:menu_sel+1.
    5. Match against key_table, lowest index wins on duplicate codes: menu_sel<=i.
    6. No match: no change.
  - In LOCKED:
    - BACK_CODE: locked<=0, back_pulse<=1, state<=BROWSE; menu_sel retained.
    - All other make bytes are ignored. menu_sel is frozen while locked.
- Latency: menu_sel, locked and pulses update on the clock edge that samples the strobe, i.e. visible the cycle after the strobe. Pulses are exactly one cycle wide.
- Back-to-back strobes on consecutive cycles are each processed; no strobe is dropped.
- Arithmetic: indices are SEL_W bits. Wrap compares against NUM_ITEMS-1, not 2^SEL_W-1.
- enable deassert while LOCKED: remain LOCKED. Reassert resumes without loss of state.

Test Plan:
1. reset=1 for 2 cycles, then idle -> menu_sel=0, locked=0, no pulses.
2. NUM_ITEMS=4: strobe 72 three times, then 72 again -> menu_sel 1,2,3,0. Strobe 75 from 0 -> 3. Sequence E0,72 from 0 -> 1.
3. key_table={8'h26,8'h1E,8'h16,8'h45} (items 3..0). Strobe 1E -> menu_sel=2. Sequence F0,16 -> menu_sel stays 2, brk_flag cleared.
4. Strobe 5A -> confirm_pulse high 1 cycle, locked=1. Strobes 72 and 16 -> menu_sel unchanged. Strobe 76 -> back_pulse 1 cycle, locked=0, menu_sel unchanged.
5. enable=0: strobe 72 -> no change. Then F0 with enable=0, enable=1, then 72 -> no change (consumed as release). Then 72 -> menu_sel+1.
6. Sequence E0,F0 then assert reset before the release byte; then strobe 72 -> menu_sel=1 (prefix discarded, from reset value 0).
